apb4_regbank_slave: RTL
=======================

Name: apb4_regbank_slave

Overview:
- Parametrised APB4 completer with an integrated register bank of NREG words.
- Adds programmable wait states, byte-lane write strobes, per-register read-only mapping with hardware-supplied read-only values, and PSLVERR generation for out-of-range, misaligned and read-only-write accesses.
- Sits on the APB bus behind the bridge and replaces the fixed slave-plus-register-file pair for peripheral control/status space.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 32, address width in bits.
- NREG, 16, number of DW-wide registers; must be ≥2.
- WAIT_CYC, 2, wait states inserted in every access phase; legal range 0..15.
- RO_MASK, 0, NREG-bit mask; bit i=1 makes register i read-only.

Ports:
- PCLK  input  1  bus clock; all state updates on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  AW  byte address.
- PWDATA  input  DW  write data.
- PSTRB  input  DW/8  write byte-lane strobes.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  transfer error; qualified by PREADY.
- PRDATA  output  DW  read data.
- ro_data  input  NREG*DW  hardware values returned for read-only registers; register i is slice [i*DW +: DW].
- reg_q  output  NREG*DW  current contents of all writable registers to the core; read-only slices are 0.

Behaviour:
- Reset (PRESETn=0, asynchronous) forces:
  - FSM to IDLE and wait counter to 0.
  - All writable registers to 0.
  - PREADY, PSLVERR and PRDATA to 0.
- Reset asserted mid-transfer aborts the transfer with no register update.
- FSM states and transitions:
  - IDLE → SETUP when PSEL=1 and PENABLE=0.
  - SETUP → ACCESS unconditionally. In the SETUP cycle, latch PADDR, PWRITE, PWDATA, PSTRB and load the wait counter with WAIT_CYC.
  - ACCESS while counter≠0: decrement the counter; PREADY=0.
  - ACCESS with counter=0: PREADY=1 for exactly one cycle. Next state is SETUP if PSEL=1 and PENABLE=0 at that edge, otherwise IDLE. Back-to-back transfers add no idle cycle.
  - PSEL=0 in ACCESS before completion (protocol violation): return to IDLE with no write and no PREADY.
- Latency: a transfer completes WAIT_CYC+1 cycles after the SETUP cycle. With WAIT_CYC=0, PREADY is high in the first access cycle (2-cycle APB transfer).
- Decode and error rules, evaluated on the latched address:
  - Register index idx = addr>>2 (word addressing, also for DW>32).
  - Error if addr[1:0]≠0, if idx≥NREG (all upper address bits are compared), or on a write to an RO_MASK register.
  - Reads of read-only registers are legal.
- PSLVERR is 1 only in the PREADY cycle of an errored transfer and 0 at all other times.
- Errored write: no register changes.
- Errored read: PRDATA=0.
- Write commit: at the rising edge where state=ACCESS and PREADY=1 and there is no error. For each byte lane b with PSTRB[b]=1, reg[idx] byte b takes the PWDATA byte; lanes with strobe 0 hold their value. PSTRB=0 is a legal no-op write with PSLVERR=0.
- Read data: PRDATA is driven only in the PREADY cycle of a read, and is 0 otherwise, including during writes.
  - Writable register: returns the registered value.
  - Read-only register: returns the ro_data slice, sampled in the PREADY cycle.
- A read of a register in the cycle after a write to it returns the new value.
- reg_q updates on the commit edge; no additional latency.
- PWDATA/PADDR changes after SETUP have no effect on the transfer.

Test Plan:
- Reset then a read of reg 0 at 0x00 (WAIT_CYC=2) → PREADY low 2 cycles, then high 1 cycle; PRDATA=0x00000000; PSLVERR=0.
- Write 0xDEADBEEF to 0x04 with PSTRB=0xF, then write 0x11223344 to 0x04 with PSTRB=0x5 → read of 0x04 returns 0xDE22BE44; reg_q slice 1 matches after the second commit edge.
- Out-of-range read at 0x40 (NREG=16), misaligned write at 0x06, and write to a read-only register (RO_MASK=0x0008, addr 0x0C) → each gets PSLVERR=1 with PREADY. Read-back shows no change; PRDATA=0 for the errored read.
- RO_MASK bit 3 set with ro_data slice 3=0xCAFE0001 → read of 0x0C returns 0xCAFE0001 with PSLVERR=0.
- WAIT_CYC=0 with back-to-back write then read of 0x08 (PSEL held high) → each transfer takes 2 cycles with no idle gap; the read returns the value just written.
- PRESETn pulsed low during a write's wait state → no register update; PREADY=0; all regs read 0 afterwards. Also PSEL dropped mid-wait → FSM returns to IDLE; the next transfer completes normally.

Source files
------------

// File: rtl/apb4_regbank_slave.sv
// APB4 completer with NREG-word register bank, byte strobes, read-only slots and PSLVERR decode.
// Latency: PREADY WAIT_CYC+1 cycles after the setup cycle; back-to-back transfers add no idle cycle.
module apb4_regbank_slave #(
  parameter int unsigned     DW       = 32,
  parameter int unsigned     AW       = 32,
  parameter int unsigned     NREG     = 16,
  parameter int unsigned     WAIT_CYC = 2,
  parameter logic [NREG-1:0] RO_MASK  = '0
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [AW-1:0]      PADDR,
  input  logic [DW-1:0]      PWDATA,
  input  logic [DW/8-1:0]    PSTRB,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic [DW-1:0]      PRDATA,
  input  logic [NREG*DW-1:0] ro_data,
  output logic [NREG*DW-1:0] reg_q
);
  localparam int unsigned IW = $clog2(NREG);
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state_q, state_d, cur_state;
  logic [3:0]      cnt_q, cnt_d;
  logic            done;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   strb_q;
  logic [DW-1:0]   regs_q [NREG];
  logic [IW-1:0]   idx;
  logic            in_range, ro_sel, err;
  logic [DW-1:0]   rd_sel;

  // The setup cycle is recognised combinationally so a new transfer can start right after PREADY.
  always_comb begin
    cur_state = state_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    if (state_q == IDLE && PSEL && !PENABLE) cur_state = SETUP;
    case (cur_state)
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYC);
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (cur_state == SETUP) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // Decode: every address bit above the word index takes part in the range check.
  assign idx      = addr_q[2 +: IW];
  assign in_range = (addr_q >> 2) < AW'(NREG);

  always_comb begin
    rd_sel = '0;
    ro_sel = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == IW'(i)) begin
        ro_sel = RO_MASK[i];
        rd_sel = RO_MASK[i] ? ro_data[i*DW +: DW] : regs_q[i];
      end
    end
  end

  assign err = (addr_q[1:0] != 2'b00) || !in_range || (write_q && ro_sel);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (done && write_q && !err) begin
      for (int i = 0; i < NREG; i++) begin
        if (idx == IW'(i)) begin
          for (int b = 0; b < SW; b++) begin
            if (strb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  assign PREADY  = done;
  assign PSLVERR = done && err;
  assign PRDATA  = (done && !write_q && !err) ? rd_sel : '0;

  for (genvar i = 0; i < NREG; i++) begin : g_reg_q
    assign reg_q[i*DW +: DW] = RO_MASK[i] ? '0 : regs_q[i];
  end
endmodule
